// File: rtl/inst_mem_server.sv
// Instruction memory with a one-cycle registered read port for fetch and a
// byte-stream program loader that holds fetch off with stall while it writes.
module inst_mem_server #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int DEPTH = 1024,
    parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] read_addr,
    output logic [DATA_W-1:0] read_data,
    output logic              read_err,
    output logic              stall,
    input  logic              load_start,
    input  logic [ADDR_W-1:0] load_base,
    input  logic [ADDR_W-1:0] load_len,
    input  logic [7:0]        load_byte,
    input  logic              load_byte_valid,
    output logic              load_ready,
    output logic              load_done
);
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] remaining;
    logic [1:0]        byte_idx;
    logic [DATA_W-1:0] word;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              addr_in_range;
    logic              read_in_range;

    assign addr_in_range = 32'(addr) < 32'(DEPTH);
    assign read_in_range = 32'(read_addr) < 32'(DEPTH);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (load_start) state_next = (load_len != '0) ? COLLECT : DONE;
            COLLECT: if (load_byte_valid && byte_idx == 2'd3) state_next = WRITE;
            WRITE:   state_next = (remaining == ADDR_W'(1)) ? DONE : COLLECT;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        stall      = (state == COLLECT) || (state == WRITE);
        load_ready = (state == COLLECT);
        load_done  = (state == DONE);
    end

    // Loader datapath; a reset mid-word drops whatever bytes were gathered.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr      <= '0;
            remaining <= '0;
            byte_idx  <= '0;
            word      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_start && load_len != '0) begin
                        addr      <= load_base;
                        remaining <= load_len;
                        byte_idx  <= '0;
                    end
                end
                COLLECT: begin
                    if (load_byte_valid) begin
                        word[{byte_idx, 3'b000} +: 8] <= load_byte;
                        byte_idx <= byte_idx + 2'd1;
                    end
                end
                WRITE: begin
                    addr      <= addr + ADDR_W'(1);
                    remaining <= remaining - ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Array is intentionally never cleared so a reset keeps the loaded program.
    always_ff @(posedge clk) begin
        if (!rst && state == WRITE && addr_in_range)
            mem[addr[IDX_W-1:0]] <= word;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            read_data <= NOP_WORD;
            read_err  <= 1'b0;
        end else if (stall) begin
            read_data <= NOP_WORD;
            read_err  <= 1'b0;
        end else if (read_in_range) begin
            read_data <= mem[read_addr[IDX_W-1:0]];
            read_err  <= 1'b0;
        end else begin
            read_data <= NOP_WORD;
            read_err  <= 1'b1;
        end
    end
endmodule
